// File: rtl/bus_pkg.sv
// Shared definitions for the serial bus slave port: frame field widths,
// read/write encoding, FSM state encoding and burst decoding.
package bus_pkg;

  localparam int HDR_BITS = 18;
  localparam int ID_W     = 2;
  localparam int BURST_W  = 3;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_IGNORE = 3'd2,
    ST_WDATA  = 3'd3,
    ST_RREQ   = 3'd4,
    ST_RWAIT  = 3'd5,
    ST_RDATA  = 3'd6
  } state_e;

  function automatic logic [BURST_W:0] beats_from_burst(input logic [BURST_W-1:0] burst);
    return {1'b0, burst} + {{BURST_W{1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/serial_shifter.sv
// Parameterised shift register: parallel load has priority over a right
// shift that enters at the MSB; q[0] is the serial output.
module serial_shifter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift_en,
  input  logic         shift_in,
  output logic [W-1:0] q
);

  logic [W-1:0] q_r;

  // shift register state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_r <= {W{1'b0}};
    end else if (load) begin
      q_r <= load_data;
    end else if (shift_en) begin
      q_r <= {shift_in, q_r[W-1:1]};
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/bus_slave_port.sv
// Serial-bus slave port: decodes bit-serial request frames, filters on
// SLAVE_ID, drives a synchronous memory port and shifts read data back.
module bus_slave_port
  import bus_pkg::*;
#(
  parameter logic [1:0] SLAVE_ID = 2'd0,
  parameter int         ADDR_W   = 12,
  parameter int         DATA_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bus_valid,
  input  logic              bus_data,
  output logic              s_rvalid,
  output logic              s_rdata,
  output logic              s_ack,
  output logic              slave_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int HDR_LEN = ID_W + 1 + BURST_W + ADDR_W;
  // The last header/data bit is taken straight from bus_data, so one bit less is stored.
  localparam int SH_W    = HDR_LEN - 1;
  localparam int CNT_W   = $clog2(HDR_LEN);

  state_e              state_r, state_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [BURST_W:0]    beats_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [DATA_W-1:0]   mem_wdata_r;
  logic                mem_we_r, mem_re_r, s_ack_r, s_rvalid_r, busy_r;
  logic                mem_we_s, mem_re_s, s_ack_s, s_rvalid_s, busy_s;

  logic [SH_W-1:0]     hdr_q_s;
  logic [DATA_W:0]     rd_q_s;
  logic                hdr_shift_s, rd_load_s;
  logic [DATA_W:0]     rd_load_data_s;

  logic [ID_W-1:0]     id_s;
  logic                id_check_s, id_bad_s, hdr_id_ok_s, hdr_rw_s;
  logic [BURST_W-1:0]  hdr_burst_s;
  logic [ADDR_W-1:0]   hdr_addr_s;
  logic [DATA_W-1:0]   wdata_s;
  logic                hdr_done_s, beat_done_s, rbit_done_s, last_beat_s;

  assign id_s        = {bus_data, hdr_q_s[SH_W-1]};
  assign id_check_s  = (state_r == ST_HDR) && (cnt_r == CNT_W'(1));
  assign id_bad_s    = id_check_s && (id_s != SLAVE_ID);
  assign hdr_id_ok_s = (hdr_q_s[ID_W-1:0] == SLAVE_ID);
  assign hdr_rw_s    = hdr_q_s[ID_W];
  assign hdr_burst_s = hdr_q_s[ID_W+1 +: BURST_W];
  assign hdr_addr_s  = {bus_data, hdr_q_s[SH_W-1 -: ADDR_W-1]};
  assign wdata_s     = {bus_data, hdr_q_s[SH_W-1 -: DATA_W-1]};
  assign hdr_done_s  = (state_r == ST_HDR) && bus_valid && (cnt_r == CNT_W'(HDR_LEN-1));
  assign beat_done_s = (state_r == ST_WDATA) && bus_valid && (cnt_r == CNT_W'(DATA_W-1));
  // A sentinel 1 loaded above the data byte marks the last bit once it reaches bit 1.
  assign rbit_done_s = (state_r == ST_RDATA) && (rd_q_s[DATA_W:1] == {{(DATA_W-1){1'b0}}, 1'b1});
  assign last_beat_s = (beats_r == {{BURST_W{1'b0}}, 1'b1});

  assign hdr_shift_s    = bus_valid && ((state_r == ST_IDLE) || (state_r == ST_HDR) || (state_r == ST_WDATA));
  assign rd_load_s      = (state_r == ST_RWAIT) || rbit_done_s;
  assign rd_load_data_s = (state_r == ST_RWAIT) ? {1'b1, mem_rdata} : {(DATA_W+1){1'b0}};

  serial_shifter #(.W(SH_W)) u_hdr_shifter (
    .clk       (clk),
    .reset     (reset),
    .load      (1'b0),
    .load_data ({SH_W{1'b0}}),
    .shift_en  (hdr_shift_s),
    .shift_in  (bus_data),
    .q         (hdr_q_s)
  );

  serial_shifter #(.W(DATA_W+1)) u_rd_shifter (
    .clk       (clk),
    .reset     (reset),
    .load      (rd_load_s),
    .load_data (rd_load_data_s),
    .shift_en  (state_r == ST_RDATA),
    .shift_in  (1'b0),
    .q         (rd_q_s)
  );

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:   state_s = bus_valid ? ST_HDR : ST_IDLE;
      ST_HDR: begin
        if (!bus_valid) begin
          state_s = ST_IDLE;
        end else if (id_bad_s) begin
          state_s = ST_IGNORE;
        end else if (hdr_done_s) begin
          if (!hdr_id_ok_s) begin
            state_s = ST_IGNORE;
          end else begin
            state_s = (hdr_rw_s == RW_READ) ? ST_RREQ : ST_WDATA;
          end
        end else begin
          state_s = ST_HDR;
        end
      end
      ST_IGNORE: state_s = bus_valid ? ST_IGNORE : ST_IDLE;
      ST_WDATA: begin
        if (!bus_valid) begin
          state_s = ST_IDLE;
        end else if (beat_done_s && last_beat_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WDATA;
        end
      end
      ST_RREQ:   state_s = ST_RWAIT;
      ST_RWAIT:  state_s = ST_RDATA;
      ST_RDATA: begin
        if (rbit_done_s) begin
          state_s = last_beat_s ? ST_IDLE : ST_RREQ;
        end else begin
          state_s = ST_RDATA;
        end
      end
      default:   state_s = ST_IDLE;
    endcase
  end

  // next values of the registered strobes and status
  always_comb begin
    mem_we_s   = beat_done_s;
    mem_re_s   = (state_s == ST_RREQ);
    s_ack_s    = (beat_done_s || rbit_done_s) && last_beat_s;
    s_rvalid_s = (state_s == ST_RDATA);
    busy_s     = (state_s != ST_IDLE);
  end

  // datapath: bit counter, beat address/count and memory port registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r       <= {CNT_W{1'b0}};
      addr_r      <= {ADDR_W{1'b0}};
      beats_r     <= {(BURST_W+1){1'b0}};
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      mem_we_r    <= 1'b0;
      mem_re_r    <= 1'b0;
      s_ack_r     <= 1'b0;
      s_rvalid_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      mem_we_r   <= mem_we_s;
      mem_re_r   <= mem_re_s;
      s_ack_r    <= s_ack_s;
      s_rvalid_r <= s_rvalid_s;
      busy_r     <= busy_s;
      case (state_r)
        ST_IDLE: cnt_r <= bus_valid ? CNT_W'(1) : {CNT_W{1'b0}};
        ST_HDR: begin
          if (hdr_done_s) begin
            cnt_r   <= {CNT_W{1'b0}};
            addr_r  <= hdr_addr_s;
            beats_r <= beats_from_burst(hdr_burst_s);
            if (hdr_rw_s == RW_READ) begin
              mem_addr_r <= hdr_addr_s;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_WDATA: begin
          if (beat_done_s) begin
            cnt_r       <= {CNT_W{1'b0}};
            mem_addr_r  <= addr_r;
            mem_wdata_r <= wdata_s;
            addr_r      <= addr_r + ADDR_W'(1);
            beats_r     <= beats_r - {{BURST_W{1'b0}}, 1'b1};
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_RDATA: begin
          if (rbit_done_s) begin
            addr_r     <= addr_r + ADDR_W'(1);
            mem_addr_r <= addr_r + ADDR_W'(1);
            beats_r    <= beats_r - {{BURST_W{1'b0}}, 1'b1};
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign mem_we     = mem_we_r;
  assign mem_re     = mem_re_r;
  assign s_ack      = s_ack_r;
  assign s_rvalid   = s_rvalid_r;
  assign s_rdata    = rd_q_s[0];
  assign slave_busy = busy_r;

endmodule

// File: doc/bus_slave_port.md
# bus_slave_port

Serial-bus responder for the shared two-master/three-slave bus. It decodes the bit-serial request frames that a master port shifts onto the bus and filters them by a fixed slave ID. It performs single or burst writes into, and reads from, a local memory over a simple synchronous memory port, and shifts read data back to the master. One instance sits in front of each slave memory (IDs 0, 1, 2).

## Interface
Parameters:
- SLAVE_ID, 0: 2-bit ID this port answers to; bits [13:12] of the master's 14-bit address.
- ADDR_W, 12: local address width; bits [11:0] of the master address.
- DATA_W, 8: data beat width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- bus_valid  in  1  master frame in progress; high for the whole request frame.
- bus_data  in  1  serial request bit, sampled on every edge while bus_valid=1.
- s_rvalid  out  1  read-data bit valid.
- s_rdata  out  1  serial read-data bit.
- s_ack  out  1  one-cycle transaction-complete pulse.
- slave_busy  out  1  high in any state other than IDLE.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_we  out  1  one-cycle write strobe.
- mem_re  out  1  one-cycle read strobe; mem_rdata valid on the following cycle.
- mem_rdata  in  DATA_W  memory read data.

## Operation
- Frame, LSB-first per field, one bit per cycle: id[1:0], rw (1=read), burst[2:0], addr[ADDR_W-1:0]. The header is 18 bits. For writes, header is followed by DATA_W bits per beat.
- Beats = burst+1, giving 1..8. Address increments by 1 per beat and wraps from 2^ADDR_W-1 to 0.
- States:
  - IDLE: first header bit is taken on the first edge with bus_valid=1.
  - HDR: collects the header.
  - IGNORE: entered when id≠SLAVE_ID after 2 bits; stays until bus_valid=0.
  - WDATA: collects one beat of write data.
  - RREQ: asserts mem_re.
  - RWAIT: latches mem_rdata.
  - RDATA: shifts out DATA_W bits.
- Write: each completed beat produces one mem_we cycle with mem_addr/mem_wdata, and reception continues without a gap. s_ack is asserted together with the last beat's mem_we, then the port returns to IDLE.
- Read: per beat, RREQ → RWAIT → RDATA, with s_rvalid=1 for DATA_W cycles and s_rdata LSB first. Next beat starts at RREQ. s_ack pulses the cycle after the last data bit, then IDLE.
- After a read header completes, bus_valid is don't-care; the read always runs to completion.
- Abort: bus_valid=0 in HDR or WDATA → IDLE next cycle.
  - The partial beat is discarded and no mem_we is issued for it.
  - Beats already written are kept.
  - No s_ack.
- ID mismatch produces no mem strobes, no s_rvalid and no s_ack.

## Timing
- Reset (reset=0): asynchronous entry to IDLE. All outputs 0, including mem_addr, mem_wdata and shift registers. Reset mid-transaction aborts with no further strobes.
- Write latency: the last data bit of a beat is sampled at edge k; mem_we is high in cycle k+1.
- Read latency: the last header bit is sampled at edge k.
  - mem_re is high in cycle k+1.
  - First s_rvalid bit appears in cycle k+3.
  - Inter-beat gap is 2 cycles with s_rvalid=0.
- A single-beat read frame occupies 18+2+DATA_W cycles before s_ack.
- bus_valid re-asserted in the same cycle the port returns to IDLE is accepted as a new frame.

## Structure
- Package bus_pkg holds:
  - HDR_BITS=18, ID_W=2, BURST_W=3.
  - RW_READ/RW_WRITE encodings.
  - State enum.
  - Beats-from-burst function.
- Sub-module serial_shifter: a parameterised width shift register with load, shift-in and shift-out. It is instantiated once for header/write-data capture and once for read-data output.

## Test plan
- SLAVE_ID=0, write id0 burst0 addr 1001 data 101 → one mem_we with mem_addr=1001, mem_wdata=101; s_ack in the same cycle.
- SLAVE_ID=0, read addr 1001 with mem_rdata=101 → mem_re once, then s_rvalid for 8 cycles carrying 1,0,1,0,0,1,1,0; s_ack the next cycle.
- SLAVE_ID=1, burst=1 write addr 4095 (master addr 8191), data 102, 103 → mem_we at 4095 with 102, then at 0 with 103.
- SLAVE_ID=1, frame for master addr 9193 (id 2) → no mem_we, mem_re or s_ack; slave_busy until bus_valid=0.
- Write frame aborted after 4 data bits (bus_valid=0) → no mem_we, IDLE and slave_busy=0 next cycle.
- reset=0 during RDATA of a read → s_rvalid and slave_busy drop immediately, and no s_ack.
